cheshire_fpga_rst_seq: RTL

Reset and boot sequencer for the Cheshire FPGA top level. It synchronizes and debounces the board reset button, waits for the clock source to report lock, and holds the SoC in reset for a programmable interval. It latches `boot_mode` at reset release and generates the SoC `rtc_i` square wave from the system clock. It sits between the board pins/clock buffer and `cheshire_soc` (`rst_ni`, `boot_mode_i`, `rtc_i`).

---
 rtl/cheshire_fpga_rst_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cheshire_fpga_rst_seq.sv
// Reset and boot sequencer for the Cheshire FPGA top level: synchronizes and debounces the
// board reset button, qualifies clock lock, holds the SoC in reset, latches boot mode, makes rtc.
module cheshire_fpga_rst_seq #(
  parameter int unsigned SysClkFreq     = 50_000_000,
  parameter int unsigned RtcFreq        = 1_000_000,
  parameter int unsigned DebounceCycles = 1_000_000,
  parameter int unsigned HoldCycles     = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_i,
  input  logic       clk_locked_i,
  input  logic [1:0] boot_mode_i,
  input  logic       test_mode_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       rtc_o,
  output logic [1:0] state_o
);

  localparam int unsigned RtcHalf = SysClkFreq / (2 * RtcFreq);
  localparam int unsigned RtcW    = (RtcHalf > 1) ? $clog2(RtcHalf) : 1;
  localparam int unsigned DbW     = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int unsigned HoldW   = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  localparam logic [RtcW-1:0]  RtcMax  = RtcW'(RtcHalf - 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);

  if (SysClkFreq < 2 * RtcFreq) begin : g_bad_rtc_freq
    $error("cheshire_fpga_rst_seq: SysClkFreq must be at least 2*RtcFreq");
  end
  if (DebounceCycles < 1) begin : g_bad_debounce
    $error("cheshire_fpga_rst_seq: DebounceCycles must be at least 1");
  end
  if (HoldCycles < 1) begin : g_bad_hold
    $error("cheshire_fpga_rst_seq: HoldCycles must be at least 1");
  end

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StHold = 2'd1,
    StRun  = 2'd2
  } state_e;

  logic [1:0] btn_sync_q, lock_sync_q;
  logic [1:0] boot_s1_q, boot_s2_q;
  logic       btn_sync, lock_sync;

  // Button synchronizer resets to "pressed" so the SoC stays held until the button is seen released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_sync_q  <= 2'b11;
      lock_sync_q <= 2'b00;
      boot_s1_q   <= 2'b00;
      boot_s2_q   <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      btn_sync_q  <= {btn_sync_q[0], btn_rst_i};
      lock_sync_q <= {lock_sync_q[0], clk_locked_i};
      boot_s1_q   <= boot_mode_i;
      boot_s2_q   <= boot_s1_q;
    end
  end

  assign btn_sync  = btn_sync_q[1];
  assign lock_sync = lock_sync_q[1];

  logic           btn_db_q;
  logic [DbW-1:0] db_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else if (btn_sync == btn_db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbMax) begin
      btn_db_q <= btn_sync;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  logic ok;
  assign ok = lock_sync & ~btn_db_q;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             soc_rst_q, soc_rst_d;
  logic [1:0]       boot_q, boot_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StWait;
      hold_cnt_q <= '0;
      soc_rst_q  <= 1'b0;
      boot_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      soc_rst_q  <= soc_rst_d;
      boot_q     <= boot_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    soc_rst_d  = soc_rst_q;
    boot_d     = boot_q;
    case (state_q)
      StWait: begin
        soc_rst_d = 1'b0;
        if (ok) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        soc_rst_d  = 1'b0;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (!ok) begin
          state_d    = StWait;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldMax) begin
          state_d    = StRun;
          hold_cnt_d = '0;
          soc_rst_d  = 1'b1;
          boot_d     = boot_s2_q;
        end
      end
      StRun: begin
        soc_rst_d = 1'b1;
        if (!ok) begin
          state_d   = StWait;
          soc_rst_d = 1'b0;
        end
      end
      default: begin
        state_d    = StWait;
        hold_cnt_d = '0;
        soc_rst_d  = 1'b0;
      end
    endcase
  end

  logic [RtcW-1:0] rtc_cnt_q;
  logic            rtc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_cnt_q <= '0;
      rtc_q     <= 1'b0;
    end else if (rtc_cnt_q == RtcMax) begin
      rtc_cnt_q <= '0;
      rtc_q     <= ~rtc_q;
    end else begin
      rtc_cnt_q <= rtc_cnt_q + 1'b1;
    end
  end

  // DFT bypass hands the board reset straight to the SoC; the FSM keeps running underneath.
  assign soc_rst_no  = test_mode_i ? rst_ni : soc_rst_q;
  assign boot_mode_o = boot_q;
  assign rtc_o       = rtc_q;
  assign state_o     = state_q;

endmodule
